// File: rtl/sd_block_writer.sv
// sd_block_writer: streams blocks*512 bytes from a source read port to an SD
// card with CMD25 (multi-block write), driving a shared SPI byte engine.
// Optional feature macro: SD_WR_CRC16_EN. When it is defined, a real
// CRC-16-CCITT is sent after each block. When it is not defined, 0xFF 0xFF is
// sent instead.
module sd_block_writer #(
  parameter logic [15:0] DATA_DIV   = 16'd2,
  parameter logic [7:0]  R1_TRIES   = 8'd16,
  parameter logic [23:0] WAIT_BYTES = 24'd2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] spi_div,
  output logic        spi_start,
  output logic [7:0]  spi_mosi,
  input  logic        spi_busy,
  input  logic        spi_done,
  input  logic [7:0]  spi_miso,
  output logic        sd_cs_n,
  input  logic        start,
  input  logic [31:0] lba_start,
  input  logic [31:0] blocks,
  output logic        rd_en,
  output logic [31:0] raddr,
  input  logic [7:0]  rdata,
  output logic        busy,
  output logic        block_done,
  output logic        all_done,
  output logic        error
);

  typedef enum logic [3:0] {
    IDLE, CMD, R1, GAP, TOKEN, FETCH, DATA, CRC, DRESP, BUSYW,
    STOPTOK, STOPGAP, STOPBUSY, TAIL, DONE, ERR
  } state_t;

  // Byte phases: SEND and WAIT drive the SPI handshake. READ and CAPT are
  // used only in DATA, to fetch the next source byte.
  localparam logic [1:0] PH_SEND = 2'd0;
  localparam logic [1:0] PH_WAIT = 2'd1;
  localparam logic [1:0] PH_READ = 2'd2;
  localparam logic [1:0] PH_CAPT = 2'd3;

  state_t      state, state_n;
  logic [1:0]  phase, phase_n;
  logic [23:0] cnt, cnt_n, cnt_inc;
  logic [31:0] lba, lba_n, remaining, remaining_n, raddr_n;
  logic [7:0]  spi_mosi_n, tx_byte;
  logic        spi_start_n, rd_en_n, sd_cs_n_n, busy_n;
  logic        block_done_n, all_done_n, error_n, byte_fin;

`ifdef SD_WR_CRC16_EN
  logic [15:0] crc, crc_n;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction
`endif

  assign spi_div = DATA_DIV;
  assign cnt_inc = cnt + 24'd1;

  // Register every piece of state and every output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= PH_SEND;
      cnt        <= '0;
      lba        <= '0;
      remaining  <= '0;
      raddr      <= '0;
      spi_start  <= 1'b0;
      spi_mosi   <= 8'hFF;
      rd_en      <= 1'b0;
      sd_cs_n    <= 1'b1;
      busy       <= 1'b0;
      block_done <= 1'b0;
      all_done   <= 1'b0;
      error      <= 1'b0;
`ifdef SD_WR_CRC16_EN
      crc        <= '0;
`endif
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      cnt        <= cnt_n;
      lba        <= lba_n;
      remaining  <= remaining_n;
      raddr      <= raddr_n;
      spi_start  <= spi_start_n;
      spi_mosi   <= spi_mosi_n;
      rd_en      <= rd_en_n;
      sd_cs_n    <= sd_cs_n_n;
      busy       <= busy_n;
      block_done <= block_done_n;
      all_done   <= all_done_n;
      error      <= error_n;
`ifdef SD_WR_CRC16_EN
      crc        <= crc_n;
`endif
    end
  end

  // Select the byte that the current state puts on MOSI.
  always_comb begin
    tx_byte = 8'hFF;
    case (state)
      CMD: begin
        case (cnt[2:0])
          3'd0:    tx_byte = 8'h59;
          3'd1:    tx_byte = lba[31:24];
          3'd2:    tx_byte = lba[23:16];
          3'd3:    tx_byte = lba[15:8];
          3'd4:    tx_byte = lba[7:0];
          default: tx_byte = 8'hFF;
        endcase
      end
      TOKEN:   tx_byte = 8'hFC;
      DATA:    tx_byte = spi_mosi;
`ifdef SD_WR_CRC16_EN
      CRC:     tx_byte = cnt[0] ? crc[7:0] : crc[15:8];
`endif
      STOPTOK: tx_byte = 8'hFD;
      default: tx_byte = 8'hFF;
    endcase
  end

  // Compute the next state and next outputs. The SPI handshake is shared by
  // every state that transfers a byte.
  always_comb begin
    state_n      = state;
    phase_n      = phase;
    cnt_n        = cnt;
    lba_n        = lba;
    remaining_n  = remaining;
    raddr_n      = raddr;
    spi_start_n  = 1'b0;
    spi_mosi_n   = spi_mosi;
    rd_en_n      = 1'b0;
    sd_cs_n_n    = sd_cs_n;
    busy_n       = busy;
    block_done_n = 1'b0;
    all_done_n   = 1'b0;
    error_n      = error;
    byte_fin     = 1'b0;
`ifdef SD_WR_CRC16_EN
    crc_n        = crc;
`endif

    if (state != IDLE && state != FETCH && state != DONE && state != ERR) begin
      if (phase == PH_SEND && !spi_busy) begin
        spi_start_n = 1'b1;
        spi_mosi_n  = tx_byte;
        phase_n     = PH_WAIT;
      end else if (phase == PH_WAIT && spi_done) begin
        byte_fin = 1'b1;
        phase_n  = PH_SEND;
      end
    end

    case (state)
      IDLE: begin
        if (start && !busy) begin
          if (blocks != 32'd0) begin
            lba_n       = lba_start;
            remaining_n = blocks;
            raddr_n     = '0;
            cnt_n       = '0;
            sd_cs_n_n   = 1'b0;
            busy_n      = 1'b1;
            phase_n     = PH_SEND;
            state_n     = CMD;
          end else begin
            all_done_n = 1'b1;
          end
        end
      end
      CMD: if (byte_fin) begin
        if (cnt == 24'd5) begin
          cnt_n   = '0;
          state_n = R1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      R1: if (byte_fin) begin
        if (!spi_miso[7]) state_n = (spi_miso == 8'h00) ? GAP : ERR;
        else if (cnt_inc >= {16'd0, R1_TRIES}) state_n = ERR;
        else cnt_n = cnt_inc;
      end
      GAP: if (byte_fin) state_n = TOKEN;
      TOKEN: if (byte_fin) begin
        cnt_n   = '0;
        state_n = FETCH;
`ifdef SD_WR_CRC16_EN
        crc_n   = '0;
`endif
      end
      FETCH: begin
        rd_en_n = 1'b1;
        phase_n = PH_READ;
        state_n = DATA;
      end
      DATA: begin
        if (phase == PH_READ) begin
          raddr_n = raddr + 32'd1;
          phase_n = PH_CAPT;
        end else if (phase == PH_CAPT) begin
          spi_mosi_n = rdata;
          phase_n    = PH_SEND;
`ifdef SD_WR_CRC16_EN
          crc_n      = crc16_byte(crc, rdata);
`endif
        end else if (byte_fin) begin
          if (cnt == 24'd511) begin
            cnt_n   = '0;
            state_n = CRC;
          end else begin
            cnt_n   = cnt_inc;
            state_n = FETCH;
          end
        end
      end
      CRC: if (byte_fin) begin
        if (cnt[0]) begin
          cnt_n   = '0;
          state_n = DRESP;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      DRESP: if (byte_fin) begin
        cnt_n   = '0;
        state_n = ((spi_miso & 8'h1F) == 8'h05) ? BUSYW : ERR;
      end
      BUSYW: if (byte_fin) begin
        if (spi_miso == 8'hFF) begin
          block_done_n = 1'b1;
          remaining_n  = remaining - 32'd1;
          cnt_n        = '0;
          state_n      = (remaining == 32'd1) ? STOPTOK : TOKEN;
        end else if (cnt_inc >= WAIT_BYTES) begin
          state_n = ERR;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      STOPTOK: if (byte_fin) state_n = STOPGAP;
      STOPGAP: if (byte_fin) begin
        cnt_n   = '0;
        state_n = STOPBUSY;
      end
      STOPBUSY: if (byte_fin) begin
        if (spi_miso == 8'hFF) begin
          sd_cs_n_n = 1'b1;
          state_n   = TAIL;
        end else if (cnt_inc >= WAIT_BYTES) begin
          state_n = ERR;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      TAIL: begin
        sd_cs_n_n = 1'b1;
        if (byte_fin) state_n = DONE;
      end
      DONE: begin
        all_done_n = 1'b1;
        busy_n     = 1'b0;
        state_n    = IDLE;
      end
      ERR: begin
        sd_cs_n_n = 1'b1;
        error_n   = 1'b1;
        busy_n    = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_block_writer.sv
// tb_sd_block_writer: directed bench for sd_block_writer. It includes an SPI
// byte engine, an SD card model that parses the MOSI stream, and a source
// memory model.
module tb_sd_block_writer;

  logic        clk = 1'b0;
  logic        rst, start, spi_busy, spi_done, rd_en, sd_cs_n;
  logic        spi_start, busy, block_done, all_done, error;
  logic [15:0] spi_div;
  logic [7:0]  spi_mosi, spi_miso, rdata;
  logic [31:0] lba_start, blocks, raddr;

  localparam int C_CMD = 0, C_R1 = 1, C_WTOK = 2, C_DRX = 3;
  localparam int C_DRESP = 4, C_BUSY = 5, C_STOPG = 6, C_END = 7;

  logic [7:0]  r1_val, reply, crc_hi, crc_lo;
  int          reject_blk;
  bit          busy_forever, fill_ff, stopping, eng_busy;
  int          card_st, ccnt, blk_idx, eng_timer;
  int          tokens, stops, data_errs, polls, log_n;
  logic [47:0] cmd_log;
  int          rd_count, addr_errs, block_done_cnt, all_done_cnt;
  logic [31:0] last_addr, next_addr;
  int          checks = 0;
  int          failures = 0;

  sd_block_writer #(.WAIT_BYTES(24'd10)) dut (
    .clk(clk), .rst(rst), .spi_div(spi_div), .spi_start(spi_start),
    .spi_mosi(spi_mosi), .spi_busy(spi_busy), .spi_done(spi_done),
    .spi_miso(spi_miso), .sd_cs_n(sd_cs_n), .start(start),
    .lba_start(lba_start), .blocks(blocks), .rd_en(rd_en), .raddr(raddr),
    .rdata(rdata), .busy(busy), .block_done(block_done),
    .all_done(all_done), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_data(input logic [31:0] a);
    return fill_ff ? 8'hFF : (a[7:0] ^ a[15:8] ^ 8'h5A);
  endfunction

  // Source memory: the read data appears one cycle after rd_en.
  always @(posedge clk) if (rd_en) rdata <= exp_data(raddr);

  assign spi_busy = eng_busy;

  // SPI byte engine plus the SD card model that answers each byte.
  always @(posedge clk) begin
    if (rst) begin
      eng_busy <= 1'b0; spi_done <= 1'b0; spi_miso <= 8'hFF; eng_timer <= 0;
      reply <= 8'hFF; card_st <= C_CMD; ccnt <= 0; blk_idx <= 0; stopping <= 1'b0;
      tokens <= 0; stops <= 0; data_errs <= 0; polls <= 0; log_n <= 0;
      cmd_log <= '0; crc_hi <= 8'h00; crc_lo <= 8'h00;
    end else begin
      spi_done <= 1'b0;
      if (eng_busy) begin
        if (eng_timer == 0) begin
          spi_done <= 1'b1; eng_busy <= 1'b0; spi_miso <= reply;
        end else eng_timer <= eng_timer - 1;
      end else if (spi_start) begin
        eng_busy <= 1'b1; eng_timer <= 2;
        if (log_n < 6) begin cmd_log <= {cmd_log[39:0], spi_mosi}; log_n <= log_n + 1; end
        case (card_st)
          C_CMD: begin
            reply <= 8'hFF;
            if (ccnt == 5) begin card_st <= C_R1; ccnt <= 0; end else ccnt <= ccnt + 1;
          end
          C_R1: begin
            if (ccnt == 0) begin reply <= 8'hFF; ccnt <= 1; end
            else begin reply <= r1_val; card_st <= C_WTOK; end
          end
          C_WTOK: begin
            reply <= 8'hFF;
            if (spi_mosi == 8'hFC) begin tokens <= tokens + 1; card_st <= C_DRX; ccnt <= 0; end
            else if (spi_mosi == 8'hFD) begin stops <= stops + 1; card_st <= C_STOPG; end
          end
          C_DRX: begin
            reply <= 8'hFF;
            if (ccnt < 512) begin
              if (spi_mosi != exp_data(32'(blk_idx * 512 + ccnt))) data_errs <= data_errs + 1;
            end else if (ccnt == 512) crc_hi <= spi_mosi;
            else crc_lo <= spi_mosi;
            if (ccnt == 513) card_st <= C_DRESP;
            ccnt <= ccnt + 1;
          end
          C_DRESP: begin
            reply <= (blk_idx == reject_blk) ? 8'h0B : 8'hE5;
            blk_idx <= blk_idx + 1; card_st <= C_BUSY; ccnt <= 0;
          end
          C_BUSY: begin
            polls <= polls + 1;
            if (busy_forever || ccnt < 3) begin reply <= 8'h00; ccnt <= ccnt + 1; end
            else begin reply <= 8'hFF; card_st <= stopping ? C_END : C_WTOK; end
          end
          C_STOPG: begin reply <= 8'hFF; stopping <= 1'b1; card_st <= C_BUSY; ccnt <= 0; end
          default: reply <= 8'hFF;
        endcase
      end
    end
  end

  // Monitor the source port and the status pulses between clock edges.
  always @(negedge clk) begin
    if (rst) begin
      rd_count <= 0; addr_errs <= 0; block_done_cnt <= 0; all_done_cnt <= 0;
      last_addr <= '0; next_addr <= '0;
    end else begin
      if (rd_en) begin
        rd_count  <= rd_count + 1;
        if (raddr != next_addr) addr_errs <= addr_errs + 1;
        last_addr <= raddr;
        next_addr <= raddr + 32'd1;
      end
      if (block_done) block_done_cnt <= block_done_cnt + 1;
      if (all_done) all_done_cnt <= all_done_cnt + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] lba, input logic [31:0] nblk,
                               input logic [7:0] r1, input int rej, input bit bforever,
                               input bit ff, input int restart_at);
    bit finished;
    r1_val = r1; reject_blk = rej; busy_forever = bforever; fill_ff = ff;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    lba_start = lba; blocks = nblk; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_on_start", 64'(busy), 64'(nblk != 0));
    checkOutput("cs_on_start", 64'(sd_cs_n), 64'(nblk == 0));
    finished = 1'b0;
    for (int i = 0; i < 20000 && !finished; i++) begin
      @(negedge clk);
      start = (i == restart_at);
      if (i == restart_at) begin blocks = 32'd1; lba_start = 32'h0000_1234; end
      if (all_done_cnt > 0 || error) finished = 1'b1;
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("finish_in_time", 64'(finished), 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; lba_start = '0; blocks = '0;
    r1_val = 8'h00; reject_blk = -1; busy_forever = 1'b0; fill_ff = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cs", 64'(sd_cs_n), 64'd1);
    checkOutput("rst_mosi", 64'(spi_mosi), 64'hFF);
    checkOutput("rst_outs", 64'({spi_start, rd_en, busy, block_done, all_done, error}), 64'd0);
    checkOutput("rst_raddr", 64'(raddr), 64'd0);
    checkOutput("spi_div", 64'(spi_div), 64'd2);

    $display("[TB] zero blocks");
    applyStimulus(32'h0, 32'd0, 8'h00, -1, 1'b0, 1'b0, -1);
    checkOutput("zero_all_done", 64'(all_done_cnt), 64'd1);
    checkOutput("zero_busy", 64'(busy), 64'd0);
    checkOutput("zero_rd", 64'(rd_count), 64'd0);

    $display("[TB] single block");
    applyStimulus(32'h0000_0800, 32'd1, 8'h00, -1, 1'b0, 1'b0, -1);
    checkOutput("single_cmd", 64'(cmd_log), 64'h59_00_00_08_00_FF);
    checkOutput("single_tokens", 64'(tokens), 64'd1);
    checkOutput("single_rd", 64'(rd_count), 64'd512);
    checkOutput("single_last_addr", 64'(last_addr), 64'd511);
    checkOutput("single_data", 64'(data_errs + addr_errs), 64'd0);
    checkOutput("single_stop", 64'(stops), 64'd1);
    checkOutput("single_block_done", 64'(block_done_cnt), 64'd1);
    checkOutput("single_all_done", 64'(all_done_cnt), 64'd1);
    checkOutput("single_error", 64'(error), 64'd0);
    checkOutput("single_cs_end", 64'(sd_cs_n), 64'd1);
    checkOutput("single_busy_end", 64'(busy), 64'd0);
`ifndef SD_WR_CRC16_EN
    checkOutput("single_crc", 64'({crc_hi, crc_lo}), 64'hFFFF);
`endif

    $display("[TB] three blocks with ignored restart");
    applyStimulus(32'h0000_0100, 32'd3, 8'h00, -1, 1'b0, 1'b0, 100);
    checkOutput("multi_cmd", 64'(cmd_log), 64'h59_00_00_01_00_FF);
    checkOutput("multi_tokens", 64'(tokens), 64'd3);
    checkOutput("multi_rd", 64'(rd_count), 64'd1536);
    checkOutput("multi_last_addr", 64'(last_addr), 64'd1535);
    checkOutput("multi_data", 64'(data_errs + addr_errs), 64'd0);
    checkOutput("multi_block_done", 64'(block_done_cnt), 64'd3);
    checkOutput("multi_stop", 64'(stops), 64'd1);
    checkOutput("multi_all_done", 64'(all_done_cnt), 64'd1);
    checkOutput("multi_error", 64'(error), 64'd0);

    $display("[TB] R1 reject");
    applyStimulus(32'h0, 32'd1, 8'h04, -1, 1'b0, 1'b0, -1);
    checkOutput("r1_error", 64'(error), 64'd1);
    checkOutput("r1_cs", 64'(sd_cs_n), 64'd1);
    checkOutput("r1_rd", 64'(rd_count), 64'd0);
    checkOutput("r1_busy", 64'(busy), 64'd0);

    $display("[TB] data reject on block 2");
    applyStimulus(32'h0, 32'd4, 8'h00, 1, 1'b0, 1'b0, -1);
    checkOutput("drej_error", 64'(error), 64'd1);
    checkOutput("drej_block_done", 64'(block_done_cnt), 64'd1);
    checkOutput("drej_all_done", 64'(all_done_cnt), 64'd0);
    checkOutput("drej_cs", 64'(sd_cs_n), 64'd1);

    $display("[TB] busy timeout");
    applyStimulus(32'h0, 32'd1, 8'h00, -1, 1'b1, 1'b0, -1);
    checkOutput("tmo_error", 64'(error), 64'd1);
    checkOutput("tmo_polls", 64'(polls), 64'd10);
    checkOutput("tmo_block_done", 64'(block_done_cnt), 64'd0);

    $display("[TB] CRC of all-FF block");
    applyStimulus(32'h0, 32'd1, 8'h00, -1, 1'b0, 1'b1, -1);
`ifdef SD_WR_CRC16_EN
    checkOutput("crc_bytes", 64'({crc_hi, crc_lo}), 64'h7FA1);
`else
    checkOutput("crc_bytes", 64'({crc_hi, crc_lo}), 64'hFFFF);
`endif
    checkOutput("crc_error", 64'(error), 64'd0);

    $display("[TB] reset mid-transfer");
    fill_ff = 1'b0; busy_forever = 1'b0; reject_blk = -1; r1_val = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    blocks = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    checkOutput("mid_cs_active", 64'(sd_cs_n), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_cs_abort", 64'(sd_cs_n), 64'd1);
    checkOutput("mid_busy_abort", 64'({busy, rd_en}), 64'd0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_block_writer.md
SD_BLOCK_WRITER -- requirements
Module: sd_block_writer

Interface
REQ-001 SHALL have parameter DATA_DIV, 16'd2, SPI clock divider driven on spi_div while owning the bus.
REQ-002 SHALL have parameter R1_TRIES, 8'd16, maximum 0xFF poll bytes while waiting for the CMD25 R1 response.
REQ-003 SHALL have parameter WAIT_BYTES, 24'd2_000_000, maximum poll bytes per card-busy wait.
REQ-004 SHALL have port clk  in  1  system clock; all logic is on the rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports spi_div out 16, spi_start out 1, spi_mosi out 8, spi_busy in 1, spi_done in 1, spi_miso in 8, which together form the shared SPI byte-engine interface.
REQ-007 SHALL have port sd_cs_n  out  1  card chip select, active low.
REQ-008 SHALL have ports start in 1 (one-cycle request pulse), lba_start in 32 (address passed verbatim to CMD25), and blocks in 32 (number of 512-byte blocks).
REQ-009 SHALL have ports rd_en out 1, raddr out 32, and rdata in 8, forming the source read port; rdata is valid exactly 1 cycle after rd_en.
REQ-010 SHALL have status ports busy out 1, block_done out 1 (pulse), all_done out 1 (pulse), and error out 1 (sticky).

Function
REQ-011 SHALL perform every byte transfer as follows: when spi_busy=0, pulse spi_start for 1 cycle with spi_mosi valid; then wait for the spi_done pulse; spi_miso is sampled only in the spi_done cycle.
REQ-012 SHALL use states IDLE, CMD, R1, GAP, TOKEN, FETCH, DATA, CRC, DRESP, BUSYW, STOPTOK, STOPGAP, STOPBUSY, TAIL, DONE, ERR.
REQ-013 IDLE: on start with blocks!=0, SHALL latch lba_start and blocks, clear raddr to 0, drive sd_cs_n=0 and busy=1, and go to CMD; with blocks==0, SHALL pulse all_done on the next cycle, keep CS high, and stay idle.
REQ-014 SHALL ignore start while busy=1.
REQ-015 CMD: SHALL send 6 bytes, 0x59, lba[31:24], lba[23:16], lba[15:8], lba[7:0], 0xFF, then go to R1.
REQ-016 R1: SHALL send 0xFF until spi_miso[7]==0; if the response is 0x00, go to GAP; if it is nonzero, or R1_TRIES bytes pass without a response, go to ERR.
REQ-017 GAP: SHALL send one 0xFF, then go to TOKEN; TOKEN SHALL send 0xFC, then go to FETCH.
REQ-018 FETCH/DATA: SHALL pulse rd_en with the current raddr, capture rdata the following cycle, send it as one SPI byte, and increment raddr after it is issued; 512 bytes per block, then go to CRC.
REQ-019 CRC: SHALL send 2 bytes, 0xFF 0xFF (see REQ-029), then go to DRESP.
REQ-020 DRESP: SHALL send 0xFF; if (spi_miso & 0x1F)==0x05, go to BUSYW; otherwise go to ERR.
REQ-021 BUSYW: SHALL send 0xFF until spi_miso==0xFF, then pulse block_done and decrement the remaining count; if the count becomes 0, go to STOPTOK, else go to TOKEN; if WAIT_BYTES is exceeded, go to ERR.
REQ-022 STOPTOK: SHALL send 0xFD; STOPGAP SHALL send one 0xFF; STOPBUSY SHALL wait as in BUSYW (same timeout), then go to TAIL.
REQ-023 TAIL: SHALL drive sd_cs_n=1 and send one 0xFF, then go to DONE; DONE SHALL pulse all_done for 1 cycle, clear busy, and return to IDLE.
REQ-024 ERR: SHALL drive sd_cs_n=1, set error=1, clear busy, and hold until reset.
REQ-025 Total bytes fetched SHALL be blocks*512, with raddr running 0 to blocks*512-1 and wrapping modulo 2^32 without a flag.
REQ-026 spi_div SHALL equal DATA_DIV at all times.

Reset
REQ-027 On rst SHALL set state=IDLE, sd_cs_n=1, spi_start=0, spi_mosi=0xFF, rd_en=0, raddr=0, busy=0, block_done=0, all_done=0, error=0, and clear all counters.
REQ-028 A reset asserted mid-transfer SHALL abort immediately, with CS high on the next cycle; the card is not re-synchronised by this block.

Configuration
REQ-029 SHALL define macro SD_WR_CRC16_EN; when defined, the block SHALL compute CRC-16-CCITT (poly 0x1021, init 0x0000) over each block's 512 data bytes and send it MSB byte first in CRC; when undefined, CRC SHALL send 0xFF 0xFF with no CRC logic compiled.

Verification
REQ-030 SHALL test single block: blocks=1, lba=0x00000800, card model returns R1=0x00, data response 0xE5, 3 busy bytes -> MOSI shows 59 00 00 08 00 FF, then FC, 512 bytes from addr 0-511, then FD; one block_done pulse, one all_done pulse, error=0.
REQ-031 SHALL test multi-block: blocks=3 -> three FC tokens, 1536 rd_en pulses, raddr ends at 1535, three block_done pulses, then FD and all_done.
REQ-032 SHALL test R1 reject: R1=0x04 -> ERR, error=1, CS high, rd_en never asserted.
REQ-033 SHALL test data reject: data response 0x0B on block 2 of 4 -> error=1 after exactly one block_done pulse.
REQ-034 SHALL test busy timeout: WAIT_BYTES=10, MISO held 0x00 -> error=1 after 10 poll bytes in BUSYW.
REQ-035 SHALL test CRC: with SD_WR_CRC16_EN defined and a block of all 0xFF data -> CRC bytes 0x7F 0xA1; without the macro -> FF FF.
